// File: rtl/ltc2308_scan_master_if.sv
// Host-side read port of the LTC2308 scan master: channel select, result word and status.
interface ltc2308_scan_master_if #(
    parameter int BUS_WIDTH = 32
) ();
    logic [2:0]           rd_addr;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 busy;
    logic                 scan_done;

    modport slave  (input  rd_addr, output rd_data, busy, scan_done);
    modport master (output rd_addr, input  rd_data, busy, scan_done);
endinterface

// File: rtl/ltc2308_scan_master.sv
// SPI initiator that scans LTC2308 channels 0..NUM_CH-1 and keeps the latest sample per channel.
// Build option: `define LTC2308_AVG4_EN stores the mean of every 4 samples instead of the raw value.
module ltc2308_scan_master #(
    parameter int CONV_CYCLES = 80,
    parameter int SCK_DIV     = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int NUM_CH      = 8,
    parameter int BUS_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    ltc2308_scan_master_if.slave bus,
    output logic                 adc_convst_o,
    output logic                 adc_sck_o,
    output logic                 adc_sdi_o,
    input  logic                 adc_sdo_i
);
    // state | meaning
    // IDLE  | stopped, channel pointer and prime flag cleared
    // CONV  | CONVST high while the ADC converts
    // SETUP | first config bit presented on SDI
    // SHIFT | 12 SCK periods: result in, next config out
    // STORE | result written to the previous frame's channel
    // GAP   | idle spacing before the next conversion
    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_SETUP, S_SHIFT, S_STORE, S_GAP
    } state_t;

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        sck_q, sck_d;
    logic [3:0]  bit_q, bit_d;
    logic [2:0]  cfg_ch_q, cfg_ch_d;
    logic [2:0]  res_ch_q, res_ch_d;
    logic        prime_q, prime_d;
    logic [1:0]  rise_q;
    logic [1:0]  sdo_sync_q;
    logic [11:0] shreg_q;
    logic [11:0] sample_q [8];
    logic [7:0]  valid_q;
    logic        tick, rise_now, fall_now, store_en;
    logic [5:0]  cfg_word;
    logic [2:0]  sdi_idx;

    if (SCK_DIV < 2) begin : g_sck_div_chk
        $error("ltc2308_scan_master: SCK_DIV < 2 samples SDO one bit late");
    end

    assign tick     = (timer_q == '0);
    assign rise_now = (state_q == S_SHIFT) && tick && !sck_q;
    assign fall_now = (state_q == S_SHIFT) && tick && sck_q;
    assign store_en = (state_q == S_STORE) && prime_q;
    assign cfg_word = {1'b1, cfg_ch_q[0], cfg_ch_q[2], cfg_ch_q[1], 1'b1, 1'b0};
    assign sdi_idx  = 3'd5 - bit_q[2:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable_i) state_d = S_CONV;
            S_CONV:  if (tick) state_d = S_SETUP;
            S_SETUP: state_d = S_SHIFT;
            S_SHIFT: if (fall_now && bit_q == 4'd11) state_d = S_STORE;
            S_STORE: state_d = S_GAP;
            S_GAP:   if (tick) state_d = enable_i ? S_CONV : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.scan_done = store_en && (res_ch_q == LAST_CH);
        adc_convst_o  = (state_q == S_CONV);
        adc_sck_o     = sck_q;
        adc_sdi_o     = 1'b0;
        if ((state_q == S_SETUP || state_q == S_SHIFT) && bit_q < 4'd6)
            adc_sdi_o = cfg_word[sdi_idx];
    end

    // One down-counter serves CONV length, SCK half-periods and the GAP.
    always_comb begin
        timer_d  = tick ? timer_q : timer_q - 16'd1;
        sck_d    = sck_q;
        bit_d    = bit_q;
        cfg_ch_d = cfg_ch_q;
        res_ch_d = res_ch_q;
        prime_d  = prime_q;
        case (state_q)
            S_IDLE: begin
                cfg_ch_d = '0;
                prime_d  = 1'b0;
            end
            S_CONV: bit_d = '0;
            S_SHIFT: if (tick) begin
                timer_d = 16'(SCK_DIV - 1);
                sck_d   = !sck_q;
                if (sck_q) bit_d = bit_q + 4'd1;
            end
            S_STORE: begin
                res_ch_d = cfg_ch_q;
                cfg_ch_d = (cfg_ch_q == LAST_CH) ? 3'd0 : cfg_ch_q + 3'd1;
                prime_d  = 1'b1;
            end
            default: ;
        endcase
        if (state_d != state_q) begin
            case (state_d)
                S_CONV:  timer_d = 16'(CONV_CYCLES - 1);
                S_SHIFT: timer_d = 16'(SCK_DIV - 1);
                S_GAP:   timer_d = 16'(GAP_CYCLES - 1);
                default: ;
            endcase
        end
    end

    // SDO passes two sync flops, so each bit is taken two clks after its internal SCK rise.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timer_q    <= '0;
            sck_q      <= 1'b0;
            bit_q      <= '0;
            cfg_ch_q   <= '0;
            res_ch_q   <= '0;
            prime_q    <= 1'b0;
            rise_q     <= '0;
            sdo_sync_q <= '0;
            shreg_q    <= '0;
        end else begin
            timer_q    <= timer_d;
            sck_q      <= sck_d;
            bit_q      <= bit_d;
            cfg_ch_q   <= cfg_ch_d;
            res_ch_q   <= res_ch_d;
            prime_q    <= prime_d;
            rise_q     <= {rise_q[0], rise_now};
            sdo_sync_q <= {sdo_sync_q[0], adc_sdo_i};
            if (rise_q[1]) shreg_q <= {shreg_q[10:0], sdo_sync_q[1]};
        end
    end

`ifdef LTC2308_AVG4_EN
    logic [13:0] acc_q [8];
    logic [1:0]  cnt_q [8];
    logic [13:0] acc_sum;

    assign acc_sum = acc_q[res_ch_q] + 14'(shreg_q);
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            for (int i = 0; i < 8; i++) begin
                sample_q[i] <= '0;
`ifdef LTC2308_AVG4_EN
                acc_q[i]    <= '0;
                cnt_q[i]    <= '0;
`endif
            end
        end else if (store_en) begin
`ifdef LTC2308_AVG4_EN
            if (cnt_q[res_ch_q] == 2'd3) begin
                sample_q[res_ch_q] <= acc_sum[13:2];
                valid_q[res_ch_q]  <= 1'b1;
                acc_q[res_ch_q]    <= '0;
                cnt_q[res_ch_q]    <= '0;
            end else begin
                acc_q[res_ch_q]    <= acc_sum;
                cnt_q[res_ch_q]    <= cnt_q[res_ch_q] + 2'd1;
            end
`else
            sample_q[res_ch_q] <= shreg_q;
            valid_q[res_ch_q]  <= 1'b1;
`endif
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if ({1'b0, bus.rd_addr} < 4'(NUM_CH)) begin
            bus.rd_data[BUS_WIDTH-1] = valid_q[bus.rd_addr];
            bus.rd_data[11:0]        = sample_q[bus.rd_addr];
        end
    end
endmodule

// File: tb/tb_ltc2308_scan_master.sv
// Directed bench: an 8-channel and a 3-channel scan master, each driving an LTC2308 model.
module tb_ltc2308_scan_master;
    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    logic [1:0]  en, busy_w, convst_w, sck_w, sdi_w, done_w;
    logic [2:0]  rd_addr_t [2];
    logic [31:0] rd_data_w [2];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int NCH = (g == 0) ? 8 : 3;
        logic sdo = 1'b0;

        ltc2308_scan_master_if #(.BUS_WIDTH(32)) bus_if ();

        ltc2308_scan_master #(.NUM_CH(NCH)) dut (
            .clk_i        (clk),
            .reset_n_i    (rst_n),
            .enable_i     (en[g]),
            .bus          (bus_if.slave),
            .adc_convst_o (convst_w[g]),
            .adc_sck_o    (sck_w[g]),
            .adc_sdi_o    (sdi_w[g]),
            .adc_sdo_i    (sdo)
        );

        assign bus_if.rd_addr = rd_addr_t[g];
        assign rd_data_w[g]   = bus_if.rd_data;
        assign busy_w[g]      = bus_if.busy;
        assign done_w[g]      = bus_if.scan_done;

        // ADC model: converts the channel configured in the previous frame, returns ch*256+ch
        logic [5:0]  cfg_sr = '0;
        logic [5:0]  cfg_log [64];
        logic [2:0]  next_ch = '0;
        logic [2:0]  conv_ch = '0;
        logic [11:0] out_sr = '0;
        int n_cfg = 0, n_rise = 0, n_frames = 0, n_done = 0, n_ch0 = 0;

        always @(posedge convst_w[g]) begin
            conv_ch = next_ch;
            n_rise  = 0;
            n_frames++;
        end

        always @(negedge convst_w[g]) begin
            #1;
            out_sr = {1'b0, conv_ch, 5'b0, conv_ch};
`ifdef LTC2308_AVG4_EN
            if (g == 0 && conv_ch == 3'd0 && n_frames > 1) begin
                out_sr = 12'(100 + n_ch0);
                n_ch0++;
            end
`endif
            sdo = out_sr[11];
        end

        always @(posedge sck_w[g]) begin
            if (n_rise < 6) cfg_sr = {cfg_sr[4:0], sdi_w[g]};
            n_rise++;
            if (n_rise == 6) begin
                next_ch = {cfg_sr[3], cfg_sr[2], cfg_sr[4]};
                if (n_cfg < 64) cfg_log[n_cfg] = cfg_sr;
                n_cfg++;
            end
        end

        always @(negedge sck_w[g]) begin
            #1;
            out_sr = {out_sr[10:0], 1'b0};
            sdo    = out_sr[11];
        end

        always @(negedge clk) if (done_w[g]) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames0(input int target, input int budget);
        int k = 0;
        while (g_inst[0].n_frames < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (g_inst[0].n_frames < target) begin
            checks++;
            errors++;
            $error("FAIL timeout_frame observed=%0d expected=%0d", g_inst[0].n_frames, target);
        end
    endtask

    task automatic wait_sck_rise0();
        int k = 0;
        while (!sck_w[0] && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("sck_rise_seen", {31'b0, sck_w[0]}, 32'd1);
    endtask

    function automatic logic [5:0] cfg_of(input int c);
        logic [2:0] cc = 3'(c);
        return {1'b1, cc[0], cc[2], cc[1], 1'b1, 1'b0};
    endfunction

    initial begin
        int n, base;
        logic prev;
        rst_n = 1'b0;
        en = 2'b00;
        rd_addr_t[0] = '0;
        rd_addr_t[1] = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy",   {30'b0, busy_w},   32'd0);
        chk("rst_convst", {30'b0, convst_w}, 32'd0);
        chk("rst_sck",    {30'b0, sck_w},    32'd0);
        chk("rst_sdi",    {30'b0, sdi_w},    32'd0);
        chk("rst_done",   {30'b0, done_w},   32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr_t[0] = 3'(a);
            #1 chk($sformatf("rst_rd%0d", a), rd_data_w[0], 32'd0);
        end

        // Test 1: first frame
        rst_n = 1'b1;
        @(negedge clk);
        en = 2'b11;
        n = 0;
        while (!convst_w[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_convst_start", {31'b0, convst_w[0]}, 32'd1);
        n = 0;
        while (convst_w[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t1_convst_len", n, 32'd80);
        wait_frames0(2, 400);
        chk("t1_cfg_ch0", {26'b0, g_inst[0].cfg_log[0]}, 32'b100010);
        for (int a = 0; a < 8; a++) begin
            rd_addr_t[0] = 3'(a);
            #1 chk($sformatf("t1_no_write%0d", a), rd_data_w[0], 32'd0);
        end

        // Test 2 and 3: nine frames on both instances
        wait_frames0(10, 1500);
        chk("t2_done_count", g_inst[0].n_done, 32'd1);
        chk("t2_cfg_ch5", {26'b0, g_inst[0].cfg_log[5]}, 32'b111010);
`ifndef LTC2308_AVG4_EN
        rd_addr_t[0] = 3'd3;
        #1 chk("t2_rd3", rd_data_w[0], 32'h8000_0303);
        rd_addr_t[0] = 3'd7;
        #1 chk("t2_rd7", rd_data_w[0], 32'h8000_0707);
        rd_addr_t[0] = 3'd0;
        #1 chk("t2_rd0", rd_data_w[0], 32'h8000_0000);
        rd_addr_t[1] = 3'd2;
        #1 chk("t3_rd2", rd_data_w[1], 32'h8000_0202);
`endif
        for (int i = 0; i < 9; i++)
            chk($sformatf("t3_cfg%0d", i), {26'b0, g_inst[1].cfg_log[i]}, {26'b0, cfg_of(i % 3)});
        chk("t3_done_count", g_inst[1].n_done, 32'd2);
        rd_addr_t[1] = 3'd5;
        #1 chk("t3_rd5", rd_data_w[1], 32'd0);
        rd_addr_t[1] = 3'd3;
        #1 chk("t3_rd3", rd_data_w[1], 32'd0);

`ifdef LTC2308_AVG4_EN
        // Test 6: ch0 sees 100..103 in frames 2, 10, 18, 26
        rd_addr_t[0] = 3'd0;
        wait_frames0(19, 1500);
        #1 chk("t6_three_samples", rd_data_w[0], 32'd0);
        wait_frames0(27, 1500);
        #1 chk("t6_avg", rd_data_w[0], 32'h8000_0065);
`endif

        // Test 5: reset in the middle of SHIFT
        wait_sck_rise0();
        rst_n = 1'b0;
        #1;
        chk("t5_sck",    {30'b0, sck_w},    32'd0);
        chk("t5_convst", {30'b0, convst_w}, 32'd0);
        chk("t5_busy",   {30'b0, busy_w},   32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr_t[0] = 3'(a);
            #1 chk($sformatf("t5_rd%0d", a), rd_data_w[0], 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = g_inst[0].n_frames;
        wait_frames0(base + 2, 400);
        rd_addr_t[0] = 3'd0;
        #1 chk("t5_frame1_discard", rd_data_w[0], 32'd0);

        // Test 4: drop enable during SHIFT of frame 4
        wait_frames0(base + 4, 600);
        wait_sck_rise0();
        en[0] = 1'b0;
        prev = sck_w[0];
        n = 0;
        for (int k = 0; k < 200 && n < 12; k++) begin
            @(negedge clk);
            if (prev && !sck_w[0]) n++;
            prev = sck_w[0];
        end
        chk("t4_falls", n, 32'd12);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy_w[0] && n < 20);
        chk("t4_idle_delay", n, 32'd5);
`ifndef LTC2308_AVG4_EN
        rd_addr_t[0] = 3'd2;
        #1 chk("t4_rd2", rd_data_w[0], 32'h8000_0202);
        rd_addr_t[0] = 3'd1;
        #1 chk("t4_rd1_kept", rd_data_w[0], 32'h8000_0101);
`endif
        rd_addr_t[0] = 3'd3;
        #1 chk("t4_rd3", rd_data_w[0], 32'd0);
        base = g_inst[0].n_frames;
        repeat (300) @(negedge clk);
        chk("t4_no_convst", g_inst[0].n_frames, base);
        chk("t4_busy_low", {31'b0, busy_w[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
